// File: rtl/fifo_read_checker.sv
// fifo_read_checker: checks that the FIFO read stream is an incrementing sequence and keeps statistics.
module fifo_read_checker #(
  parameter int DATA_WIDTH    = 8,
  parameter int READ_LATENCY  = 1,
  parameter int COUNT_WIDTH   = 16,
  parameter int LOCK_ON_FIRST = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   read_enable,
  input  logic                   empty,
  input  logic [DATA_WIDTH-1:0]  data,
  output logic [COUNT_WIDTH-1:0] read_count,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic [COUNT_WIDTH-1:0] underflow_count,
  output logic                   mismatch,
  output logic                   error_flag,
  output logic [DATA_WIDTH-1:0]  first_bad_data,
  output logic [DATA_WIDTH-1:0]  first_bad_expected,
  output logic [1:0]             state
);
  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, FAIL = 2'd2} state_t;
  state_t                 state_q, state_d;
  logic                   pipe_q;
  logic [DATA_WIDTH-1:0]  exp_q, exp_d;
  logic [COUNT_WIDTH-1:0] rc_q, ec_q, uc_q;
  logic                   mm_q, flag_q;
  logic [DATA_WIDTH-1:0]  fbd_q, fbe_q;
  logic                   acc, uflow, smp, cmp, bad;
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c, input logic en);
    return (en && c != '1) ? c + 1'b1 : c;
  endfunction
  assign acc   = read_enable & ~empty;
  assign uflow = read_enable & empty;
  assign smp   = (READ_LATENCY == 0) ? acc : pipe_q;
  assign cmp   = (state_q != IDLE) || (LOCK_ON_FIRST == 0);
  assign bad   = smp && cmp && (data != exp_q);
  // Matching or not, the next expected word is always data+1: a match equals exp+1, a mismatch resyncs.
  always_comb begin
    exp_d   = smp ? DATA_WIDTH'(data + 1'b1) : exp_q;
    state_d = !smp ? state_q : (bad || state_q == FAIL) ? FAIL : CHECK;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pipe_q  <= 1'b0;
      exp_q   <= '0;
      rc_q    <= '0;
      ec_q    <= '0;
      uc_q    <= '0;
      mm_q    <= 1'b0;
      flag_q  <= 1'b0;
      fbd_q   <= '0;
      fbe_q   <= '0;
    end else begin
      state_q <= state_d;
      pipe_q  <= acc;
      exp_q   <= exp_d;
      rc_q    <= sat_inc(rc_q, smp);
      ec_q    <= sat_inc(ec_q, bad);
      uc_q    <= sat_inc(uc_q, uflow);
      mm_q    <= bad;
      if (bad && !flag_q) begin
        flag_q <= 1'b1;
        fbd_q  <= data;
        fbe_q  <= exp_q;
      end
    end
  end
  assign read_count         = rc_q;
  assign error_count        = ec_q;
  assign underflow_count    = uc_q;
  assign mismatch           = mm_q;
  assign error_flag         = flag_q;
  assign first_bad_data     = fbd_q;
  assign first_bad_expected = fbe_q;
  assign state              = state_q;
endmodule
